// File: rtl/gfau_pkg.sv
// Shared definitions for the GF(p) arithmetic unit: opcodes, FSM states
// and the modular helpers used by both the main pipe and the divide core.
package gfau_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Helpers work on a carrier one bit wider than the largest supported
  // operand; callers zero-extend WIDTH-bit values in and cast the reduced
  // result back to WIDTH bits, so every sum keeps its carry.
  localparam int GF_MAX_W = 128;
  typedef logic [GF_MAX_W:0] gf_wide_t;

  // (x + y) mod p for x, y in [0, p-1]
  function automatic gf_wide_t mod_add(gf_wide_t x, gf_wide_t y, gf_wide_t p);
    gf_wide_t s;
    s = x + y;
    if (s >= p) s = s - p;
    return s;
  endfunction

  // (x - y) mod p for x, y in [0, p-1]; x + (p - y) lies in [0, 2p)
  function automatic gf_wide_t mod_sub(gf_wide_t x, gf_wide_t y, gf_wide_t p);
    return mod_add(x, p - y, p);
  endfunction

  // x / 2 mod p for odd p: odd x is lifted by p first to make it even
  function automatic gf_wide_t mod_half(gf_wide_t x, gf_wide_t p);
    gf_wide_t s;
    s = x[0] ? (x + p) : x;
    return s >> 1;
  endfunction

endpackage

// File: rtl/gfau_div_core.sv
// Binary extended Euclid divider: computes a * b^-1 mod p, one action per
// clock. done is combinational so the final check costs no extra cycle.
module gfau_div_core
  import gfau_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_BOUND = 4 * WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int IW = $clog2(DIV_BOUND + 1);

  logic             running_q, run_nx;
  logic [WIDTH-1:0] u_q, u_nx, v_q, v_nx;
  logic [WIDTH-1:0] x1_q, x1_nx, x2_q, x2_nx, p_q, p_nx;
  logic [IW-1:0]    iter_q, iter_nx;
  logic             u_one, v_one, limit;
  gf_wide_t         x1_w, x2_w, p_w;

  assign x1_w  = gf_wide_t'(x1_q);
  assign x2_w  = gf_wide_t'(x2_q);
  assign p_w   = gf_wide_t'(p_q);
  assign u_one = (u_q == WIDTH'(1));
  assign v_one = (v_q == WIDTH'(1));
  // Safety stop so out-of-range operands (b >= p, even p) cannot hang the unit.
  assign limit = (iter_q == IW'(DIV_BOUND));

  assign done   = running_q && (u_one || v_one || limit);
  assign result = (v_one && !u_one) ? x2_q : x1_q;

  // Next-state for the u/v/x1/x2 datapath, one Euclid action per cycle.
  always_comb begin
    run_nx  = running_q;
    u_nx    = u_q;
    v_nx    = v_q;
    x1_nx   = x1_q;
    x2_nx   = x2_q;
    p_nx    = p_q;
    iter_nx = iter_q;
    if (start) begin
      run_nx  = 1'b1;
      u_nx    = b;
      v_nx    = p;
      x1_nx   = a;
      x2_nx   = '0;
      p_nx    = p;
      iter_nx = '0;
    end else if (running_q) begin
      if (done) begin
        run_nx = 1'b0;
      end else begin
        iter_nx = iter_q + IW'(1);
        if (!u_q[0]) begin
          u_nx  = u_q >> 1;
          x1_nx = WIDTH'(mod_half(x1_w, p_w));
        end else if (!v_q[0]) begin
          v_nx  = v_q >> 1;
          x2_nx = WIDTH'(mod_half(x2_w, p_w));
        end else if (u_q >= v_q) begin
          u_nx  = u_q - v_q;
          x1_nx = WIDTH'(mod_sub(x1_w, x2_w, p_w));
        end else begin
          v_nx  = v_q - u_q;
          x2_nx = WIDTH'(mod_sub(x2_w, x1_w, p_w));
        end
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      running_q <= 1'b0;
      u_q       <= '0;
      v_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      p_q       <= '0;
      iter_q    <= '0;
    end else begin
      running_q <= run_nx;
      u_q       <= u_nx;
      v_q       <= v_nx;
      x1_q      <= x1_nx;
      x2_q      <= x2_nx;
      p_q       <= p_nx;
      iter_q    <= iter_nx;
    end
  end

  // With valid operands the algorithm always converges before the bound.
  a_div_bound : assert property (@(posedge i_clk) disable iff (!i_rst)
    running_q |-> (u_one || v_one || !limit));

endmodule

// File: rtl/gfau_pipe.sv
// GF(p) arithmetic unit with valid/ready handshake. ADD/SUB finish in the
// accept cycle, MUL runs MSB-first one bit per clock, DIV uses gfau_div_core.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// MUL     | interleaved multiply, one operand bit per cycle
// DIV     | divide core iterating
// DONE    | result presented, waiting for out_ready
module gfau_pipe
  import gfau_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_BOUND = 4 * WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx, p_q, p_nx;
  logic [WIDTH-1:0] acc_q, acc_nx, result_q, result_nx;
  logic [BW-1:0]    bit_q, bit_nx;
  logic             err_q, err_nx;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_result;
  gf_wide_t         in0_w, in1_w, prime_w, acc_w, b_w, p_w, mul_w;

  assign in0_w   = gf_wide_t'(in_0);
  assign in1_w   = gf_wide_t'(in_1);
  assign prime_w = gf_wide_t'(prime);
  assign acc_w   = gf_wide_t'(acc_q);
  assign b_w     = gf_wide_t'(b_q);
  assign p_w     = gf_wide_t'(p_q);

  // One MUL step: double, then conditionally add b; both reduced mod p.
  assign mul_w = mod_add(mod_add(acc_w, acc_w, p_w), a_q[bit_q] ? b_w : '0, p_w);

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign result    = result_q;
  assign err       = err_q;

  assign div_start = in_ready && in_valid && (op == OP_DIV) && (in_1 != '0);

  gfau_div_core #(
    .WIDTH     (WIDTH),
    .DIV_BOUND (DIV_BOUND)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .start  (div_start),
    .a      (in_0),
    .b      (in_1),
    .p      (prime),
    .done   (div_done),
    .result (div_result)
  );

  // Next-state and datapath decode for the sequencing FSM.
  always_comb begin
    state_nx  = state_q;
    a_nx      = a_q;
    b_nx      = b_q;
    p_nx      = p_q;
    acc_nx    = acc_q;
    bit_nx    = bit_q;
    result_nx = result_q;
    err_nx    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_nx   = in_0;
          b_nx   = in_1;
          p_nx   = prime;
          err_nx = 1'b0;
          case (op)
            OP_ADD: begin
              result_nx = WIDTH'(mod_add(in0_w, in1_w, prime_w));
              state_nx  = ST_DONE;
            end
            OP_SUB: begin
              result_nx = WIDTH'(mod_sub(in0_w, in1_w, prime_w));
              state_nx  = ST_DONE;
            end
            OP_MUL: begin
              acc_nx   = '0;
              bit_nx   = BW'(WIDTH - 1);
              state_nx = ST_MUL;
            end
            default: begin
              if (in_1 == '0) begin
                result_nx = '0;
                err_nx    = 1'b1;
                state_nx  = ST_DONE;
              end else begin
                state_nx = ST_DIV;
              end
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_nx = WIDTH'(mul_w);
        if (bit_q == '0) begin
          result_nx = WIDTH'(mul_w);
          state_nx  = ST_DONE;
        end else begin
          bit_nx = bit_q - BW'(1);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          result_nx = div_result;
          state_nx  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          err_nx   = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nx;
      a_q      <= a_nx;
      b_q      <= b_nx;
      p_q      <= p_nx;
      acc_q    <= acc_nx;
      bit_q    <= bit_nx;
      result_q <= result_nx;
      err_q    <= err_nx;
    end
  end

endmodule

// File: tb/tb_gfau_pipe.sv
// Scoreboard bench for gfau_pipe at WIDTH=8 and WIDTH=32.
module tb_gfau_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, ordy8, err8, busy8;
  logic [1:0] op8;
  logic [7:0] a8, b8, p8, res8;

  logic        iv32, ir32, ov32, ordy32, err32, busy32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, p32, res32;

  gfau_pipe #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .in_0(a8), .in_1(b8), .prime(p8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .err(err8), .busy(busy8)
  );

  gfau_pipe #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .in_0(a32), .in_1(b32), .prime(p32), .out_valid(ov32), .out_ready(ordy32),
    .result(res32), .err(err32), .busy(busy32)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] P32 = 32'd4294967291;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic, inverse via Fermat.
  function automatic logic [63:0] mulmod(logic [63:0] x, logic [63:0] y, logic [63:0] p);
    return (x * y) % p;
  endfunction

  function automatic logic [63:0] powmod(logic [63:0] bse, logic [63:0] e, logic [63:0] p);
    logic [63:0] r;
    r = 1;
    while (e != 0) begin
      if (e[0]) r = mulmod(r, bse, p);
      bse = mulmod(bse, bse, p);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_res(logic [1:0] o, logic [63:0] a, logic [63:0] b, logic [63:0] p);
    logic [63:0] r;
    case (o)
      2'd0:    r = (a + b) % p;
      2'd1:    r = (a + p - b) % p;
      2'd2:    r = mulmod(a, b, p);
      default: r = (b == 0) ? 64'd0 : mulmod(a, powmod(b, p - 2, p), p);
    endcase
    return r[31:0];
  endfunction

  function automatic logic get_ov(bit big);   return big ? ov32 : ov8;     endfunction
  function automatic logic get_ir(bit big);   return big ? ir32 : ir8;     endfunction
  function automatic logic get_busy(bit big); return big ? busy32 : busy8; endfunction
  function automatic logic get_err(bit big);  return big ? err32 : err8;   endfunction
  function automatic logic get_ordy(bit big); return big ? ordy32 : ordy8; endfunction
  function automatic logic [31:0] get_res(bit big);
    return big ? res32 : {24'd0, res8};
  endfunction

  // Drive one request at the negedge, push its expectation, leave #1 after accept.
  task automatic issue(input bit big, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] eres, input logic eerr);
    @(negedge clk);
    check("in_ready_before_issue", get_ir(big), 1);
    if (big) begin
      iv32 = 1'b1; op32 = o; a32 = a; b32 = b; p32 = p;
    end else begin
      iv8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0]; p8 = p[7:0];
    end
    sb.push_back('{res: eres, err: eerr});
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    iv32 = 1'b0;
    // Scramble operands: the unit must work from its latched copies.
    a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom); op8 = 2'($urandom);
    a32 = $urandom; b32 = $urandom; p32 = $urandom; op32 = 2'($urandom);
  endtask

  // Wait for out_valid, measuring edges after accept and busy cycles.
  task automatic collect(input bit big, input string tag, input int kmin, input int kmax);
    int   k;
    int   busy_n;
    exp_t e;
    k = 0;
    busy_n = 0;
    while (!get_ov(big) && k < 300) begin
      if (get_busy(big)) busy_n++;
      @(posedge clk);
      #1;
      k++;
    end
    if (kmin == kmax) check({tag, "_latency"}, k, kmin);
    else check({tag, "_latency_in_range"}, (k >= kmin && k <= kmax) ? 1 : 0, 1);
    check({tag, "_busy_cycles"}, busy_n, k);
    check({tag, "_busy_at_done"}, get_busy(big), 0);
    check({tag, "_in_ready_at_done"}, get_ir(big), 0);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_scoreboard: got output, expected nothing queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, get_res(big), e.res);
      check({tag, "_err"}, get_err(big), e.err);
    end
    if (get_ordy(big)) begin
      @(posedge clk);
      #1;
      check({tag, "_out_valid_cleared"}, get_ov(big), 0);
    end
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eres;
    logic        eerr;
    int          kmin;
    int          kmax;
  } vec_t;

  vec_t plan8[9] = '{
    '{"add_250_250", 2'd0, 250, 250, 249, 1'b0, 0, 0},
    '{"sub_5_10",    2'd1, 5,   10,  246, 1'b0, 0, 0},
    '{"mul_123_45",  2'd2, 123, 45,  13,  1'b0, 8, 8},
    '{"mul_250_250", 2'd2, 250, 250, 1,   1'b0, 8, 8},
    '{"div_10_3",    2'd3, 10,  3,   87,  1'b0, 1, 32},
    '{"div_1_3",     2'd3, 1,   3,   84,  1'b0, 1, 32},
    '{"div_7_1",     2'd3, 7,   1,   7,   1'b0, 1, 1},
    '{"div_5_0",     2'd3, 5,   0,   0,   1'b1, 0, 0},
    '{"add_1_1",     2'd0, 1,   1,   2,   1'b0, 0, 0}
  };

  int unsigned primes8[4] = '{251, 241, 13, 3};

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; p8 = '0; ordy8 = 1'b1;
    iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; p32 = '0; ordy32 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_result", res8, 0);
    check("rst_err", err8, 0);
    check("rst_busy", busy8, 0);
    check("rst_in_ready_w32", ir32, 1);
    check("rst_out_valid_w32", ov32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (plan8[i]) begin
      issue(1'b0, plan8[i].op, plan8[i].a, plan8[i].b, 32'd251, plan8[i].eres, plan8[i].eerr);
      collect(1'b0, plan8[i].tag, plan8[i].kmin, plan8[i].kmax);
    end

    // Backpressure: result must hold and new requests must be refused.
    ordy8 = 1'b0;
    issue(1'b0, 2'd2, 123, 45, 251, 13, 1'b0);
    collect(1'b0, "mul_stall", 8, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = 1'b1; op8 = 2'd0; a8 = 8'd1; b8 = 8'd1; p8 = 8'd251;
      @(posedge clk);
      #1;
      check("stall_out_valid", ov8, 1);
      check("stall_in_ready", ir8, 0);
      check("stall_result", res8, 13);
      @(negedge clk);
      iv8 = 1'b0;
    end
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_out_valid", ov8, 0);
    check("stall_release_in_ready", ir8, 1);

    // Reset in the middle of a DIV aborts it with no output.
    issue(1'b0, 2'd3, 10, 3, 251, 87, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("middiv_busy", busy8, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("middiv_rst_in_ready", ir8, 1);
    check("middiv_rst_out_valid", ov8, 0);
    check("middiv_rst_busy", busy8, 0);
    check("middiv_rst_result", res8, 0);
    check("middiv_rst_err", err8, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("middiv_no_late_output", ov8, 0);
    issue(1'b0, 2'd0, 1, 2, 251, 3, 1'b0);
    collect(1'b0, "add_after_rst", 0, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] p, a, b;
      logic [1:0]  o;
      int          kmin, kmax;
      p = primes8[$urandom_range(0, 3)];
      a = $urandom_range(0, p - 1);
      b = $urandom_range(0, p - 1);
      o = 2'($urandom_range(0, 3));
      kmin = 0; kmax = 0;
      if (o == 2'd2) begin kmin = 8; kmax = 8; end
      if (o == 2'd3 && b != 0) begin kmin = 1; kmax = 32; end
      issue(1'b0, o, a, b, p, model_res(o, a, b, p), (o == 2'd3) && (b == 0));
      collect(1'b0, "rand8", kmin, kmax);
    end

    // WIDTH=32 carry and overflow paths.
    issue(1'b1, 2'd2, P32 - 1, P32 - 1, P32, 1, 1'b0);
    collect(1'b1, "w32_mul_pm1_sq", 32, 32);
    issue(1'b1, 2'd3, 1, 2, P32, 32'd2147483646, 1'b0);
    collect(1'b1, "w32_div_1_2", 1, 128);
    issue(1'b1, 2'd0, P32 - 1, P32 - 2, P32, P32 - 3, 1'b0);
    collect(1'b1, "w32_add_wrap", 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      logic [1:0]  o;
      int          kmin, kmax;
      a = $urandom_range(0, 32'hFFFF_FFFA);
      b = $urandom_range(1, 32'hFFFF_FFFA);
      o = 2'($urandom_range(0, 3));
      kmin = 0; kmax = 0;
      if (o == 2'd2) begin kmin = 32; kmax = 32; end
      if (o == 2'd3) begin kmin = 1; kmax = 128; end
      issue(1'b1, o, a, b, P32, model_res(o, a, b, P32), 1'b0);
      collect(1'b1, "rand32", kmin, kmax);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gfau_pipe.md
Name: gfau_pipe

Overview:
- Parametrised GF(p) arithmetic unit with a valid/ready handshake. It is the successor to the fixed 32-bit add/sub/mult/div unit.
- Supports ADD, SUB, MUL and DIV (a·b⁻¹ mod p) at any odd prime width.
- Fully reduced results, a divide-by-zero flag, and output backpressure.
- Sits between the ECC point-arithmetic controller and the operand register file. One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/prime/result width in bits (≥4).
- DIV_BOUND, 4*WIDTH, maximum DIV iterations. Exceeding it is a design error, flagged by an assertion.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- in_0  in  WIDTH  operand a (DIV numerator).
- in_1  in  WIDTH  operand b (DIV denominator).
- prime  in  WIDTH  modulus p; odd, ≥3; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  result in [0, p-1].
- err  out  1  DIV with in_1==0; qualified by out_valid.
- busy  out  1  a MUL or DIV is iterating.

Behaviour:
- Reset: asynchronous, active-low. Clock is i_clk; reset is i_rst, asynchronous and active-low.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, err=0, busy=0, all internal registers 0.
  - Reset asserted mid-operation aborts the operation; no out_valid is produced for it.
- Preconditions: in_0 < p and in_1 < p. Violation gives an undefined result but no hang.
- Accept: on the edge where in_valid && in_ready, latch op, in_0, in_1 and prime. Later input changes are ignored.
- in_ready = (state==IDLE).
- States: IDLE, MUL, DIV, DONE.
- IDLE, on accept:
  - ADD: r = a+b computed at WIDTH+1 bits; subtract p if r ≥ p. Register the result, go to DONE. out_valid is high after the accept edge (latency 1).
  - SUB: r = a−b; add p if borrow. Go to DONE, latency 1.
  - MUL: acc=0, bit index = WIDTH−1, go to MUL, busy=1.
  - DIV with b==0: result=0, err=1, go to DONE, latency 1.
  - DIV with b≠0: u=b, v=p, x1=a, x2=0, go to DIV, busy=1.
- MUL (MSB-first interleaved, one bit per cycle):
  - acc = 2·acc mod p, then acc = acc + b mod p if a[bit]=1.
  - Every intermediate is held at WIDTH+1 bits and kept in [0, p−1].
  - After the bit-0 step, go to DONE. out_valid rises WIDTH cycles after the accept edge.
- DIV (binary extended Euclid, one action per cycle, priority order):
  - If u==1: result=x1, go to DONE.
  - If v==1: result=x2, go to DONE.
  - If u even: u>>=1; x1 = x1 even ? x1/2 : (x1+p)/2.
  - Else if v even: v>>=1; x2 halved the same way.
  - Else if u ≥ v: u −= v; x1 = (x1−x2) mod p.
  - Else: v −= u; x2 = (x2−x1) mod p.
  - The x+p sum is formed at WIDTH+1 bits.
  - Latency is variable, ≤ DIV_BOUND+1 cycles. b==1 finishes in 1 iteration (latency 2).
- DONE: out_valid=1; result and err held stable until out_ready. On the edge where out_valid && out_ready, clear out_valid and err and go to IDLE.
  - in_ready is 0 throughout DONE, so a new accept is possible at the earliest on the following edge.
- busy=1 only in MUL and DIV.
- No wrap-around: every stored value is < 2^WIDTH, and every sum is evaluated at WIDTH+1 bits before reduction.

Decomposition:
- gfau_pkg holds:
  - op encoding constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - state encoding;
  - a function mod_add(x,y,p) and a function mod_half(x,p), both parametrised by WIDTH.
- Sub-module gfau_div_core holds the u/v/x1/x2 datapath and iteration logic, with start/done/result ports.
- ADD, SUB and MUL stay in gfau_pipe.

Test Plan (WIDTH=8, p=251 unless noted):
- ADD 250+250 → result 249, err 0, out_valid 1 cycle after accept. SUB 5−10 → 246.
- MUL 123·45 → 13, out_valid exactly 8 cycles after accept, busy high for those 8 cycles. MUL 250·250 → 1.
- DIV 10/3 → 87; DIV 1/3 → 84; DIV 7/1 → 7. Each completes within 33 cycles.
- DIV 5/0 → result 0, err 1, latency 1. The next ADD 1+1 → 2 with err 0.
- Backpressure: hold out_ready=0 for 5 cycles after MUL completes. result stays 13, in_ready stays 0, and in_valid pulses during the stall are not accepted.
- Reset mid-DIV at cycle 4: all outputs return to reset values immediately. After release, ADD 1+2 → 3.
- WIDTH=32, p=4294967291, MUL (p−1)·(p−1) → 1, and DIV 1/2 → 2147483646; both check the carry/overflow paths.
